// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one burst memory port between an icache and a dcache requester.
// Define MEM_ARB_DCACHE_PRIORITY_EN to make dcache win every tie; default arbitration is round-robin.
module mem_arbiter #(
    parameter int ADDR_BITS = 28,
    parameter int BEATS     = 4
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 ic_req_val,
    output logic                 ic_req_rdy,
    input  logic [ADDR_BITS-1:0] ic_req_addr,
    input  logic                 ic_req_rw,
    input  logic                 ic_data_valid,
    output logic                 ic_data_ready,
    input  logic [127:0]         ic_data_bits,
    input  logic [15:0]          ic_data_mask,
    output logic                 ic_resp_val,
    output logic [127:0]         ic_resp_data,

    input  logic                 dc_req_val,
    output logic                 dc_req_rdy,
    input  logic [ADDR_BITS-1:0] dc_req_addr,
    input  logic                 dc_req_rw,
    input  logic                 dc_data_valid,
    output logic                 dc_data_ready,
    input  logic [127:0]         dc_data_bits,
    input  logic [15:0]          dc_data_mask,
    output logic                 dc_resp_val,
    output logic [127:0]         dc_resp_data,

    output logic                 mem_req_val,
    input  logic                 mem_req_rdy,
    output logic [ADDR_BITS-1:0] mem_req_addr,
    output logic                 mem_req_rw,
    output logic                 mem_req_data_valid,
    input  logic                 mem_req_data_ready,
    output logic [127:0]         mem_req_data_bits,
    output logic [15:0]          mem_req_data_mask,
    input  logic                 mem_resp_val,
    input  logic [127:0]         mem_resp_data
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, RD, WR} state_e;
    typedef enum logic {OWN_IC = 1'b0, OWN_DC = 1'b1} owner_e;

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    owner_e           winner;
    logic             any_req;
    logic             grant;
    logic             beat;

    assign any_req = ic_req_val | dc_req_val;
    assign grant   = (state_q == IDLE) && any_req && mem_req_rdy;

`ifdef MEM_ARB_DCACHE_PRIORITY_EN
    always_comb begin
        if (ic_req_val && !dc_req_val) winner = OWN_IC;
        else                           winner = OWN_DC;
    end
`else
    owner_e last_q;

    // On a tie the port that did not own the previous transaction wins.
    always_comb begin
        if (ic_req_val && dc_req_val) begin
            if (last_q == OWN_IC) winner = OWN_DC;
            else                  winner = OWN_IC;
        end else if (dc_req_val) begin
            winner = OWN_DC;
        end else begin
            winner = OWN_IC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      last_q <= OWN_DC;
        else if (grant) last_q <= winner;
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= OWN_IC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output and next-state value gets a default first so no latch is inferred.
    always_comb begin
        state_d            = state_q;
        owner_d            = owner_q;
        cnt_d              = cnt_q;
        mem_req_val        = 1'b0;
        mem_req_addr       = '0;
        mem_req_rw         = 1'b0;
        ic_req_rdy         = 1'b0;
        dc_req_rdy         = 1'b0;
        mem_req_data_valid = 1'b0;
        ic_data_ready      = 1'b0;
        dc_data_ready      = 1'b0;
        ic_resp_val        = 1'b0;
        dc_resp_val        = 1'b0;
        beat               = 1'b0;

        case (state_q)
            IDLE: begin
                mem_req_val  = any_req;
                mem_req_addr = (winner == OWN_DC) ? dc_req_addr : ic_req_addr;
                mem_req_rw   = (winner == OWN_DC) ? dc_req_rw : ic_req_rw;
                ic_req_rdy   = ic_req_val && (winner == OWN_IC) && mem_req_rdy;
                dc_req_rdy   = dc_req_val && (winner == OWN_DC) && mem_req_rdy;
                if (grant) begin
                    owner_d = winner;
                    cnt_d   = '0;
                    state_d = mem_req_rw ? WR : RD;
                end
            end
            RD: begin
                ic_resp_val = mem_resp_val && (owner_q == OWN_IC);
                dc_resp_val = mem_resp_val && (owner_q == OWN_DC);
                beat        = mem_resp_val;
            end
            WR: begin
                mem_req_data_valid = (owner_q == OWN_DC) ? dc_data_valid : ic_data_valid;
                ic_data_ready      = mem_req_data_ready && (owner_q == OWN_IC);
                dc_data_ready      = mem_req_data_ready && (owner_q == OWN_DC);
                beat               = mem_req_data_valid && mem_req_data_ready;
            end
            default: state_d = IDLE;
        endcase

        // Completion returns to IDLE; a new grant can only happen from IDLE on a later cycle.
        if (beat) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) state_d = IDLE;
        end
    end

    assign mem_req_data_bits = (owner_q == OWN_DC) ? dc_data_bits : ic_data_bits;
    assign mem_req_data_mask = (owner_q == OWN_DC) ? dc_data_mask : ic_data_mask;
    assign ic_resp_data      = mem_resp_data;
    assign dc_resp_data      = mem_resp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AB = 28;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req_val, ic_req_rdy, ic_req_rw, ic_data_valid, ic_data_ready, ic_resp_val;
    logic [AB-1:0] ic_req_addr;
    logic [127:0]  ic_data_bits, ic_resp_data;
    logic [15:0]   ic_data_mask;
    logic          dc_req_val, dc_req_rdy, dc_req_rw, dc_data_valid, dc_data_ready, dc_resp_val;
    logic [AB-1:0] dc_req_addr;
    logic [127:0]  dc_data_bits, dc_resp_data;
    logic [15:0]   dc_data_mask;
    logic          mem_req_val, mem_req_rdy, mem_req_rw, mem_req_data_valid, mem_req_data_ready;
    logic          mem_resp_val;
    logic [AB-1:0] mem_req_addr;
    logic [127:0]  mem_req_data_bits, mem_resp_data;
    logic [15:0]   mem_req_data_mask;

    int vectors     = 0;
    int miscompares = 0;
    bit last_dc;   // model: dcache owned the most recent transaction

    mem_arbiter #(.ADDR_BITS(AB), .BEATS(NB)) dut (
        .clk(clk), .reset(reset),
        .ic_req_val(ic_req_val), .ic_req_rdy(ic_req_rdy), .ic_req_addr(ic_req_addr), .ic_req_rw(ic_req_rw),
        .ic_data_valid(ic_data_valid), .ic_data_ready(ic_data_ready), .ic_data_bits(ic_data_bits),
        .ic_data_mask(ic_data_mask), .ic_resp_val(ic_resp_val), .ic_resp_data(ic_resp_data),
        .dc_req_val(dc_req_val), .dc_req_rdy(dc_req_rdy), .dc_req_addr(dc_req_addr), .dc_req_rw(dc_req_rw),
        .dc_data_valid(dc_data_valid), .dc_data_ready(dc_data_ready), .dc_data_bits(dc_data_bits),
        .dc_data_mask(dc_data_mask), .dc_resp_val(dc_resp_val), .dc_resp_data(dc_resp_data),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
        .mem_req_rw(mem_req_rw), .mem_req_data_valid(mem_req_data_valid),
        .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
        .mem_req_data_mask(mem_req_data_mask), .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Arbitration rule: a lone requester wins; a tie goes to dcache (priority build) or to the
    // port that did not own the previous transaction (round-robin build).
    function automatic bit expect_dc(bit icv, bit dcv);
        if (icv && dcv) begin
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
            return 1'b1;
`else
            return !last_dc;
`endif
        end
        return dcv;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ic_req_val = 0; ic_req_addr = '0; ic_req_rw = 0; ic_data_valid = 0; ic_data_bits = '0; ic_data_mask = '0;
        dc_req_val = 0; dc_req_addr = '0; dc_req_rw = 0; dc_data_valid = 0; dc_data_bits = '0; dc_data_mask = '0;
        mem_req_rdy = 0; mem_req_data_ready = 0; mem_resp_val = 0; mem_resp_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        nxt();
        nxt();
        reset = 0;
        last_dc = 1;
    endtask

    task automatic test_reset();
        logic [127:0] d;
        clear_inputs();
        reset = 1;
        d = rnd128();
        mem_resp_val = 1; mem_resp_data = d; mem_req_data_ready = 1; mem_req_rdy = 1;
        #1;
        vectors++;
        if ({mem_req_val, ic_req_rdy, dc_req_rdy, ic_resp_val, dc_resp_val,
             mem_req_data_valid, ic_data_ready, dc_data_ready} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 00000000", {mem_req_val, ic_req_rdy, dc_req_rdy,
                     ic_resp_val, dc_resp_val, mem_req_data_valid, ic_data_ready, dc_data_ready});
        end
        vectors++;
        if (ic_resp_data !== d || dc_resp_data !== d) begin
            miscompares++;
            $display("FAIL reset_resp_forward: got %h/%h want %h", ic_resp_data, dc_resp_data, d);
        end
        nxt();
        reset = 0;
        last_dc = 1;
        mid();
        vectors++;
        if ({ic_resp_val, dc_resp_val, mem_req_val, mem_req_data_valid} !== 4'b0000) begin
            miscompares++;
            $display("FAIL idle_drop_resp: got %b want 0000", {ic_resp_val, dc_resp_val, mem_req_val, mem_req_data_valid});
        end
        clear_inputs();
        nxt();
    endtask

    task automatic test_ic_read();
        logic [127:0] d;
        logic [7:0]   bv;
        ic_req_val = 1; ic_req_addr = 28'h0000010; ic_req_rw = 0; mem_req_rdy = 1;
        mid();
        vectors++;
        if ({mem_req_val, ic_req_rdy, dc_req_rdy, mem_req_rw} !== 4'b1100 || mem_req_addr !== 28'h10) begin
            miscompares++;
            $display("FAIL ic_read_grant: got %b addr %h want 1100 addr 0000010",
                     {mem_req_val, ic_req_rdy, dc_req_rdy, mem_req_rw}, mem_req_addr);
        end
        nxt();
        last_dc = 0;
        ic_req_val = 0; mem_req_rdy = 0;
        for (int b = 0; b < NB; b++) begin
            bv = 8'(8'h11 * (b + 1));
            d = {16{bv}};
            mem_resp_val = 1; mem_resp_data = d;
            mid();
            vectors++;
            if ({mem_req_val, ic_resp_val, dc_resp_val} !== 3'b010 || ic_resp_data !== d) begin
                miscompares++;
                $display("FAIL ic_read_beat%0d: got %b data %h want 010 data %h",
                         b, {mem_req_val, ic_resp_val, dc_resp_val}, ic_resp_data, d);
            end
            nxt();
        end
        ic_req_val = 1; mem_req_rdy = 0; mem_resp_val = 1;
        mid();
        vectors++;
        if ({mem_req_val, ic_resp_val, dc_resp_val} !== 3'b100) begin
            miscompares++;
            $display("FAIL ic_read_idle_after: got %b want 100", {mem_req_val, ic_resp_val, dc_resp_val});
        end
        clear_inputs();
        nxt();
    endtask

    task automatic test_dc_write();
        logic [127:0] dd [NB];
        bit           pat [5] = '{1, 0, 1, 1, 1};
        int           k = 0;
        for (int i = 0; i < NB; i++) dd[i] = rnd128();
        dc_req_val = 1; dc_req_addr = 28'h0000020; dc_req_rw = 1; mem_req_rdy = 1;
        dc_data_valid = 1; dc_data_bits = dd[0]; dc_data_mask = 16'hFFFF; mem_req_data_ready = 1;
        mid();
        vectors++;
        if ({mem_req_val, ic_req_rdy, dc_req_rdy, mem_req_rw, mem_req_data_valid, dc_data_ready} !== 6'b101100
            || mem_req_addr !== 28'h20) begin
            miscompares++;
            $display("FAIL dc_write_grant: got %b addr %h want 101100 addr 0000020",
                     {mem_req_val, ic_req_rdy, dc_req_rdy, mem_req_rw, mem_req_data_valid, dc_data_ready}, mem_req_addr);
        end
        nxt();
        last_dc = 1;
        dc_req_val = 0; mem_req_rdy = 0;
        for (int c = 0; c < 5; c++) begin
            mem_req_data_ready = pat[c];
            dc_data_bits = dd[k];
            mid();
            vectors++;
            if ({mem_req_data_valid, dc_data_ready, ic_data_ready} !== {1'b1, pat[c], 1'b0}
                || mem_req_data_bits !== dd[k] || mem_req_data_mask !== 16'hFFFF) begin
                miscompares++;
                $display("FAIL dc_write_cycle%0d: got %b data %h mask %h want %b data %h mask ffff", c,
                         {mem_req_data_valid, dc_data_ready, ic_data_ready}, mem_req_data_bits,
                         mem_req_data_mask, {1'b1, pat[c], 1'b0}, dd[k]);
            end
            if (pat[c]) k++;
            nxt();
        end
        dc_req_val = 1; mem_req_rdy = 0; mem_req_data_ready = 1;
        mid();
        vectors++;
        if ({mem_req_val, mem_req_data_valid, dc_data_ready} !== 3'b100) begin
            miscompares++;
            $display("FAIL dc_write_idle_after: got %b want 100", {mem_req_val, mem_req_data_valid, dc_data_ready});
        end
        clear_inputs();
        nxt();
    endtask

    // Serves a read for the model-chosen owner; rounds>1 with rerequest re-raises the winner each time.
    task automatic tie_rounds(input string tag, input int rounds, input bit rerequest);
        bit           icv = 1, dcv = 1, own;
        logic [127:0] d;
        ic_req_addr = 28'h0000100; dc_req_addr = 28'h0000200; ic_req_rw = 0; dc_req_rw = 0;
        for (int g = 0; g < rounds; g++) begin
            ic_req_val = icv; dc_req_val = dcv; mem_req_rdy = 1;
            own = expect_dc(icv, dcv);
            mid();
            vectors++;
            if ({mem_req_val, ic_req_rdy, dc_req_rdy} !== {1'b1, !own, own}
                || mem_req_addr !== (own ? 28'h200 : 28'h100)) begin
                miscompares++;
                $display("FAIL %s_grant%0d: got %b addr %h want %b", tag, g,
                         {mem_req_val, ic_req_rdy, dc_req_rdy}, mem_req_addr, {1'b1, !own, own});
            end
            nxt();
            last_dc = own;
            if (own) dcv = 0; else icv = 0;
            ic_req_val = icv; dc_req_val = dcv;
            for (int b = 0; b < NB; b++) begin
                while ($urandom_range(3, 0) == 0) begin
                    mem_resp_val = 0;
                    nxt();
                end
                d = rnd128();
                mem_resp_val = 1; mem_resp_data = d;
                mid();
                vectors++;
                if ({mem_req_val, ic_req_rdy, dc_req_rdy, ic_resp_val, dc_resp_val} !== {3'b000, !own, own}
                    || dc_resp_data !== d) begin
                    miscompares++;
                    $display("FAIL %s_beat%0d_%0d: got %b want %b", tag, g, b,
                             {mem_req_val, ic_req_rdy, dc_req_rdy, ic_resp_val, dc_resp_val}, {3'b000, !own, own});
                end
                nxt();
            end
            mem_resp_val = 0;
            if (rerequest) begin icv = 1; dcv = 1; end
        end
        clear_inputs();
        nxt();
    endtask

    task automatic test_tie();
        do_reset();
        tie_rounds("tie", 2, 0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        tie_rounds("b2b", 3, 1);
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        ic_req_val = 1; ic_req_addr = 28'h0ABCDE0; mem_req_rdy = 1;
        nxt();
        last_dc = 0;
        ic_req_val = 0; mem_req_rdy = 0;
        for (int b = 0; b < 2; b++) begin
            mem_resp_val = 1; mem_resp_data = rnd128();
            nxt();
        end
        mem_resp_val = 1; mem_resp_data = rnd128();
        #1;
        vectors++;
        if (ic_resp_val !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_beat3_before: got %b want 1", ic_resp_val);
        end
        reset = 1;
        #1;
        vectors++;
        if ({ic_resp_val, dc_resp_val} !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_mid_async: got %b want 00", {ic_resp_val, dc_resp_val});
        end
        nxt();
        reset = 0;
        last_dc = 1;
        for (int b = 0; b < 2; b++) begin
            mid();
            vectors++;
            if ({ic_resp_val, dc_resp_val, mem_req_val} !== 3'b000) begin
                miscompares++;
                $display("FAIL rst_mid_dropped%0d: got %b want 000", b, {ic_resp_val, dc_resp_val, mem_req_val});
            end
            nxt();
        end
        mem_resp_val = 0;
        tie_rounds("rst_after", 1, 0);
    endtask

    task automatic test_stall();
        logic [AB-1:0] a = AB'($urandom);
        ic_req_val = 1; ic_req_addr = a; ic_req_rw = 0; mem_req_rdy = 0;
        for (int s = 0; s < 5; s++) begin
            mid();
            vectors++;
            if ({mem_req_val, ic_req_rdy, dc_req_rdy} !== 3'b100 || mem_req_addr !== a) begin
                miscompares++;
                $display("FAIL stall%0d: got %b addr %h want 100 addr %h", s,
                         {mem_req_val, ic_req_rdy, dc_req_rdy}, mem_req_addr, a);
            end
            nxt();
        end
        mem_req_rdy = 1;
        mid();
        vectors++;
        if ({mem_req_val, ic_req_rdy} !== 2'b11 || mem_req_addr !== a) begin
            miscompares++;
            $display("FAIL stall_accept: got %b addr %h want 11 addr %h", {mem_req_val, ic_req_rdy}, mem_req_addr, a);
        end
        nxt();
        last_dc = 0;
        clear_inputs();
        mid();
        vectors++;
        if (mem_req_val !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_in_rd: got %b want 0", mem_req_val);
        end
        for (int b = 0; b < NB; b++) begin
            mem_resp_val = 1;
            nxt();
        end
        clear_inputs();
        nxt();
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int   r = $urandom_range(2, 0);
            bit   icv = (r != 1), dcv = (r != 0), own, wr, v, rdy;
            int   acc = 0, cyc = 0;
            logic [AB-1:0] ica = AB'($urandom), dca = AB'($urandom);
            logic [127:0]  d;
            ic_req_val = icv; dc_req_val = dcv; ic_req_addr = ica; dc_req_addr = dca;
            ic_req_rw = 1'($urandom); dc_req_rw = 1'($urandom);
            own = expect_dc(icv, dcv);
            wr = own ? dc_req_rw : ic_req_rw;
            for (int s = $urandom_range(2, 0); s > 0; s--) begin
                mid();
                vectors++;
                if ({mem_req_val, ic_req_rdy, dc_req_rdy} !== 3'b100) begin
                    miscompares++;
                    $display("FAIL rnd%0d_wait: got %b want 100", t, {mem_req_val, ic_req_rdy, dc_req_rdy});
                end
                nxt();
            end
            mem_req_rdy = 1;
            mid();
            vectors++;
            if ({mem_req_val, ic_req_rdy, dc_req_rdy, mem_req_rw} !== {1'b1, !own, own, wr}
                || mem_req_addr !== (own ? dca : ica)) begin
                miscompares++;
                $display("FAIL rnd%0d_grant: got %b addr %h want %b addr %h", t,
                         {mem_req_val, ic_req_rdy, dc_req_rdy, mem_req_rw}, mem_req_addr,
                         {1'b1, !own, own, wr}, own ? dca : ica);
            end
            nxt();
            last_dc = own;
            if (own) dc_req_val = 0; else ic_req_val = 0;
            while ((wr ? acc : cyc) < NB && cyc < 200) begin
                mem_req_rdy = 1'($urandom);
                v = 1'($urandom); rdy = 1'($urandom); d = rnd128();
                if (wr) begin
                    ic_data_valid = own ? 1'($urandom) : v; dc_data_valid = own ? v : 1'($urandom);
                    ic_data_bits = own ? rnd128() : d; dc_data_bits = own ? d : rnd128();
                    ic_data_mask = 16'($urandom); dc_data_mask = 16'($urandom);
                    mem_req_data_ready = rdy;
                    mid();
                    vectors++;
                    if ({mem_req_val, mem_req_data_valid, ic_data_ready, dc_data_ready} !== {1'b0, v, rdy && !own, rdy && own}
                        || (v && (mem_req_data_bits !== d || mem_req_data_mask !== (own ? dc_data_mask : ic_data_mask)))) begin
                        miscompares++;
                        $display("FAIL rnd%0d_wbeat: got %b data %h want %b data %h", t,
                                 {mem_req_val, mem_req_data_valid, ic_data_ready, dc_data_ready}, mem_req_data_bits,
                                 {1'b0, v, rdy && !own, rdy && own}, d);
                    end
                    if (v && rdy) acc++;
                end else begin
                    mem_resp_val = v; mem_resp_data = d;
                    mid();
                    vectors++;
                    if ({mem_req_val, ic_req_rdy, dc_req_rdy, ic_resp_val, dc_resp_val} !== {3'b000, v && !own, v && own}
                        || ic_resp_data !== d) begin
                        miscompares++;
                        $display("FAIL rnd%0d_rbeat: got %b want %b", t,
                                 {mem_req_val, ic_req_rdy, dc_req_rdy, ic_resp_val, dc_resp_val}, {3'b000, v && !own, v && own});
                    end
                    if (v) acc++;
                end
                nxt();
                cyc = wr ? cyc + 1 : acc;
            end
            if (wr && acc < NB) begin
                vectors++;
                miscompares++;
                $display("FAIL rnd%0d_timeout: got %0d beats want %0d", t, acc, NB);
            end
            clear_inputs();
            mem_resp_val = 1; mem_req_data_ready = 1;
            mid();
            vectors++;
            if ({mem_req_val, ic_resp_val, dc_resp_val, mem_req_data_valid, ic_data_ready, dc_data_ready} !== 6'b0) begin
                miscompares++;
                $display("FAIL rnd%0d_idle: got %b want 000000", t,
                         {mem_req_val, ic_resp_val, dc_resp_val, mem_req_data_valid, ic_data_ready, dc_data_ready});
            end
            nxt();
            clear_inputs();
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        last_dc = 1;
        test_reset();
        test_ic_read();
        test_dc_write();
        test_tie();
        test_back_to_back();
        test_reset_mid_read();
        test_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 28, memory line-address width (word address bits 29:2).
REQ-002 Parameter BEATS, default 4, 128-bit beats per transaction; power of two, 1..16.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 ic_req_val, dc_req_val  input  1  icache/dcache memory request valid.
REQ-006 ic_req_rdy, dc_req_rdy  output  1  request accepted this cycle when paired with val.
REQ-007 ic_req_addr, dc_req_addr  input  ADDR_BITS  line address.
REQ-008 ic_req_rw, dc_req_rw  input  1  0 = read, 1 = write.
REQ-009 ic_data_valid, dc_data_valid  input  1  write beat valid.
REQ-010 ic_data_ready, dc_data_ready  output  1  write beat accepted.
REQ-011 ic_data_bits, dc_data_bits  input  128  write beat data; ic_data_mask, dc_data_mask  input  16  byte mask.
REQ-012 ic_resp_val, dc_resp_val  output  1  read beat for that port; ic_resp_data, dc_resp_data  output  128.
REQ-013 mem_req_val/rdy/addr/rw, mem_req_data_valid/ready/bits/mask, mem_resp_val/data: memory side, same widths and directions reversed.

Function
REQ-014 States: IDLE, RD, WR; owner register (IC/DC); beat counter of ceilLog2(BEATS) bits, minimum 1 bit.
REQ-015 IDLE: winner chosen combinationally from asserted *_req_val; mem_req_val/addr/rw driven from winner; winner *_req_rdy = mem_req_rdy; loser *_req_rdy = 0.
REQ-016 IDLE with no requester: mem_req_val = 0, both *_req_rdy = 0.
REQ-017 On mem_req_val && mem_req_rdy in IDLE: owner <= winner, counter <= 0, state <= RD (rw=0) or WR (rw=1); zero added request latency.
REQ-018 RD: mem_resp_data forwarded to both *_resp_data; owner *_resp_val = mem_resp_val, other = 0; counter increments per mem_resp_val; on BEATS-th beat state <= IDLE.
REQ-019 WR: mem_req_data_valid/bits/mask = owner's; owner *_data_ready = mem_req_data_ready; non-owner data_ready = 0; counter increments per accepted beat; on BEATS-th beat state <= IDLE.
REQ-020 Write beats accepted only in WR, earliest the cycle after request acceptance.
REQ-021 mem_req_val = 0 and both *_req_rdy = 0 in RD and WR; no new request until return to IDLE.
REQ-022 mem_resp_val outside RD is dropped; both *_resp_val = 0.
REQ-023 Return to IDLE and new grant may not share a cycle; IDLE lasts at least one cycle.
REQ-024 Default arbitration round-robin: last-owner register updated at each acceptance; simultaneous requests grant the port that was not last owner; single requester always wins.
REQ-025 Requester must hold val/addr/rw stable until accepted; arbiter does not latch address.

Reset
REQ-026 On reset: state IDLE, counter 0, owner IC, last-owner DC (icache wins first tie); all outputs 0 except combinational data forwards.
REQ-027 Reset mid-RD or mid-WR abandons the transaction; remaining beats dropped; no partial grant survives.

Configuration
REQ-028 Macro MEM_ARB_DCACHE_PRIORITY_EN: defined -> dcache always wins simultaneous requests, last-owner register unused; undefined -> round-robin per REQ-024.

Verification
REQ-029 ic read addr 0x0000010, mem_req_rdy=1, 4 resp beats 0x11..,0x22..,0x33..,0x44.. -> mem_req_addr=0x10, ic_resp_val 4 cycles with matching data, dc_resp_val=0, IDLE after beat 4.
REQ-030 dc write addr 0x0000020, 4 beats D0..D3 mask 0xFFFF, mem_req_data_ready toggled 1,0,1,1,1 -> exactly 4 beats forwarded in order, dc_data_ready mirrors ready, IDLE after 4th.
REQ-031 ic and dc asserted together out of reset, both reads -> ic granted first, dc granted in first IDLE after ic's 4th beat; with MEM_ARB_DCACHE_PRIORITY_EN dc first.
REQ-032 Three back-to-back tie rounds -> grants alternate IC, DC, IC (round-robin build).
REQ-033 Reset asserted after 2nd read beat -> state IDLE immediately, 3rd/4th mem_resp_val produce no *_resp_val, next request granted normally.
REQ-034 mem_req_rdy held 0 for 5 cycles with ic_req_val=1 -> ic_req_rdy=0, mem_req_val=1, addr stable; accepted on cycle rdy rises.
